// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle RV64M multiply/divide controller.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle,
// with sign pre/post-processing and the RISC-V divide corner cases.
// Optional macro MDU_FAST_ZERO_EN: zero-operand multiplies, divide by zero
// and signed overflow skip the iterations and finish in one cycle.
module mdu_sequencer #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            stall,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_result
);

    localparam logic [2:0] K_MUL  = 3'd0;
    localparam logic [2:0] K_DIV  = 3'd1;
    localparam logic [2:0] K_DIVU = 3'd2;
    localparam logic [2:0] K_REM  = 3'd3;
    localparam logic [2:0] K_REMU = 3'd4;

    // Most-negative values after operand extension (W form is sign-extended).
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

`ifdef MDU_FAST_ZERO_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            w_q, w_d;
    logic [2:0]      kind_q, kind_d;
    logic [XLEN-1:0] a_q, a_d;       // multiplicand, or dividend bits / quotient
    logic [XLEN-1:0] b_q, b_d;       // multiplier, or divisor magnitude
    logic [XLEN-1:0] acc_q, acc_d;   // product, or partial remainder
    logic [XLEN-1:0] dvd_q, dvd_d;   // extended dividend, for forced corner results
    logic [XLEN-1:0] res_q, res_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            div0_q, div0_d;
    logic            ovf_q, ovf_d;

    // Request decode and operand preparation
    logic            in_w, in_legal, in_uns, in_div;
    logic [2:0]      in_kind;
    logic [XLEN-1:0] op1, op2, mag1, mag2;
    logic            in_sgn1, in_sgn2, in_div0, in_ovf, in_mul0, in_skip;

    // Iteration step results
    logic [XLEN-1:0] prod_next, rem_next, quo_next;
    logic [XLEN:0]   shifted, diff;
    logic            no_borrow;
    logic [5:0]      last;

    // Sign fix-up, corner-case forcing and W sign extension of the final result.
    function automatic logic [XLEN-1:0] finalize(
        input logic [2:0]      kind,
        input logic            w,
        input logic            div0,
        input logic            ovf,
        input logic            qneg,
        input logic            rneg,
        input logic [XLEN-1:0] dvd,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r
    );
        logic [XLEN-1:0] qs, rs, res;
        qs = qneg ? -q : q;
        rs = rneg ? -r : r;
        if (div0) begin
            qs = '1;
            rs = dvd;
        end else if (ovf) begin
            qs = dvd;
            rs = '0;
        end
        case (kind)
            K_MUL:          res = q;
            K_DIV, K_DIVU:  res = qs;
            K_REM, K_REMU:  res = rs;
            default:        res = '0;
        endcase
        if (w) res = {{(XLEN-32){res[31]}}, res[31:0]};
        return res;
    endfunction

    // Decode the incoming op, extend operands per width, detect corner cases.
    always_comb begin
        in_w     = req_op[3];
        in_kind  = req_op[2:0];
        in_legal = (in_kind <= K_REMU);
        in_uns   = (in_kind == K_DIVU) || (in_kind == K_REMU);
        in_div   = in_legal && (in_kind != K_MUL);
        if (in_w) begin
            op1 = in_uns ? {{(XLEN-32){1'b0}}, src1[31:0]} : {{(XLEN-32){src1[31]}}, src1[31:0]};
            op2 = in_uns ? {{(XLEN-32){1'b0}}, src2[31:0]} : {{(XLEN-32){src2[31]}}, src2[31:0]};
        end else begin
            op1 = src1;
            op2 = src2;
        end
        in_sgn1 = in_div && !in_uns && op1[XLEN-1];
        in_sgn2 = in_div && !in_uns && op2[XLEN-1];
        mag1    = in_sgn1 ? -op1 : op1;
        mag2    = in_sgn2 ? -op2 : op2;
        in_div0 = in_div && (op2 == '0);
        in_ovf  = in_div && !in_uns && (op2 == '1) && (op1 == (in_w ? MIN_W : MIN_X));
        in_mul0 = (in_kind == K_MUL) &&
                  (in_w ? ((op1[31:0] == 32'd0) || (op2[31:0] == 32'd0))
                        : ((op1 == '0) || (op2 == '0)));
        in_skip = FAST_ZERO && (in_mul0 || in_div0 || in_ovf);
    end

    // One multiply step and one restoring-divide step from the current registers.
    always_comb begin
        prod_next = acc_q + (b_q[0] ? a_q : '0);
        shifted   = {acc_q, a_q[XLEN-1]};
        diff      = shifted - {1'b0, b_q};
        no_borrow = !diff[XLEN];
        rem_next  = no_borrow ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_next  = {a_q[XLEN-2:0], no_borrow};
    end

    // Next-state and datapath update; flush overrides everything but reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        kind_d  = kind_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        dvd_d   = dvd_q;
        res_d   = res_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;
        last    = w_q ? 6'd31 : 6'd63;
        case (state_q)
            S_IDLE: begin
                if (req_valid && in_legal && !flush) begin
                    w_d    = in_w;
                    kind_d = in_kind;
                    cnt_d  = '0;
                    dvd_d  = op1;
                    qneg_d = in_sgn1 ^ in_sgn2;
                    rneg_d = in_sgn1;
                    div0_d = in_div0;
                    ovf_d  = in_ovf;
                    acc_d  = '0;
                    if (in_div) begin
                        // W dividends sit in the top half so the first shift brings in bit 31.
                        a_d = in_w ? {mag1[31:0], {(XLEN-32){1'b0}}} : mag1;
                        b_d = mag2;
                    end else begin
                        a_d = op1;
                        b_d = op2;
                    end
                    if (in_skip) begin
                        state_d = S_DONE;
                        res_d   = finalize(in_kind, in_w, in_div0, in_ovf, in_sgn1 ^ in_sgn2,
                                           in_sgn1, op1, '0, '0);
                    end else begin
                        state_d = in_div ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL: begin
                acc_d = prod_next;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                if (cnt_q == last) begin
                    state_d = S_DONE;
                    res_d   = finalize(kind_q, w_q, 1'b0, 1'b0, 1'b0, 1'b0, dvd_q, prod_next, '0);
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DIV: begin
                acc_d = rem_next;
                a_d   = quo_next;
                if (cnt_q == last) begin
                    state_d = S_DONE;
                    res_d   = finalize(kind_q, w_q, div0_q, ovf_q, qneg_q, rneg_q, dvd_q,
                                       quo_next, rem_next);
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (flush) state_d = S_IDLE;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            w_q     <= 1'b0;
            kind_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            dvd_q   <= '0;
            res_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            kind_q  <= kind_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            dvd_q   <= dvd_d;
            res_q   <= res_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
        end
    end

    // Stall covers the accept cycle and the iterations; DONE lets the pipe advance.
    always_comb begin
        stall       = ((state_q == S_IDLE) && req_valid && in_legal) ||
                      (state_q == S_MUL) || (state_q == S_DIV);
        resp_valid  = (state_q == S_DONE) && !flush;
        resp_result = res_q;
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: stimulus queues expected results and
// per-cycle output checks; a negedge monitor pops and compares them.
module tb_mdu_sequencer;

`ifdef MDU_FAST_ZERO_EN
    localparam int LZ64 = 1;
    localparam int LZ32 = 1;
`else
    localparam int LZ64 = 65;
    localparam int LZ32 = 33;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [63:0] src1 = 64'd0;
    logic [63:0] src2 = 64'd0;
    logic        flush = 1'b0;
    logic        stall, resp_valid;
    logic [63:0] resp_result;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] exp;
    } chk_t;

    chk_t        chk_q[$];
    logic [63:0] rexp_q[$];
    int          rcyc_q[$];

    mdu_sequencer #(.XLEN(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .src1        (src1),
        .src2        (src2),
        .flush       (flush),
        .stall       (stall),
        .resp_valid  (resp_valid),
        .resp_result (resp_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scheduled output checks, missing/unexpected/wrong responses.
    always @(negedge clk) begin : monitor
        chk_t        c;
        logic [63:0] act;
        logic [63:0] e;
        int          ec;
        string       nm;
        while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
            c = chk_q.pop_front();
            case (c.sig)
                0:       begin act = {63'd0, stall};      nm = "stall";       end
                1:       begin act = {63'd0, resp_valid}; nm = "resp_valid";  end
                default: begin act = resp_result;         nm = "resp_result"; end
            endcase
            n_vec++;
            if (act !== c.exp) begin
                n_err++;
                $display("FAIL %s cyc %0d: got %h want %h", nm, cyc, act, c.exp);
            end
        end
        if (rcyc_q.size() > 0 && rcyc_q[0] < cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL resp_missing: no resp_valid at cyc %0d (want %h)", rcyc_q[0], rexp_q[0]);
            void'(rcyc_q.pop_front());
            void'(rexp_q.pop_front());
        end
        if (resp_valid) begin
            n_vec++;
            if (rexp_q.size() == 0) begin
                n_err++;
                $display("FAIL resp_unexpected cyc %0d: got %h want none", cyc, resp_result);
            end else begin
                e  = rexp_q.pop_front();
                ec = rcyc_q.pop_front();
                if (resp_result !== e || cyc != ec) begin
                    n_err++;
                    $display("FAIL resp cyc %0d: got %h want %h at cyc %0d", cyc, resp_result, e, ec);
                end
            end
        end
    end

    task automatic expect_at(input int c, input int sig, input logic [63:0] v);
        chk_t k;
        k.cyc = c;
        k.sig = sig;
        k.exp = v;
        chk_q.push_back(k);
    endtask

    // Called just after a posedge; holds req_valid until the response cycle.
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int lat);
        int t;
        bit got;
        req_valid = 1'b1;
        req_op    = op;
        src1      = a;
        src2      = b;
        t         = cyc;
        rexp_q.push_back(exp);
        rcyc_q.push_back(t + lat);
        expect_at(t, 0, 64'd1);
        expect_at(t + lat, 0, 64'd0);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = resp_valid;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin : stim
        int t;
        // Reset state
        @(posedge clk); #1;
        expect_at(cyc, 0, 64'd0);
        expect_at(cyc, 1, 64'd0);
        expect_at(cyc, 2, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed vectors: op, src1, src2, expected, latency
        @(posedge clk); #1; issue(4'b0000, 64'd7, 64'd6, 64'd42, 65);
        @(posedge clk); #1; issue(4'b0001, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
        @(posedge clk); #1; issue(4'b0011, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        @(posedge clk); #1; issue(4'b1010, 64'h0000_0001_8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, LZ32);
        @(posedge clk); #1; issue(4'b0001, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                                  64'h8000_0000_0000_0000, LZ64);
        @(posedge clk); #1; issue(4'b0011, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, LZ64);
        @(posedge clk); #1; issue(4'b1000, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        @(posedge clk); #1; issue(4'b0010, 64'd100, 64'd7, 64'd14, 65);
        @(posedge clk); #1; issue(4'b0100, 64'd100, 64'd7, 64'd2, 65);
        @(posedge clk); #1; issue(4'b0000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 65);
        @(posedge clk); #1; issue(4'b0000, 64'd0, 64'h1234, 64'd0, LZ64);
        @(posedge clk); #1; issue(4'b1001, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        @(posedge clk); #1; issue(4'b1011, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        @(posedge clk); #1; issue(4'b1100, 64'h0000_0001_0000_000A, 64'd3, 64'd1, 33);
        @(posedge clk); #1; issue(4'b1001, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                                  64'hFFFF_FFFF_8000_0000, LZ32);
        @(posedge clk); #1; issue(4'b0011, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, LZ64);

        // Illegal kind: never accepted, never stalls
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            expect_at(cyc, 0, 64'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;

        // Request in the same cycle as flush is dropped
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = 4'b0000;
        src1      = 64'd9;
        src2      = 64'd9;
        flush     = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        expect_at(cyc, 0, 64'd0);

        // Flush a DIVU mid-flight, then MUL 3x5 at T+12
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = 4'b0010;
        src1      = 64'd100;
        src2      = 64'd7;
        t         = cyc;
        expect_at(t, 0, 64'd1);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        expect_at(cyc, 0, 64'd1);
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        expect_at(cyc, 0, 64'd0);
        expect_at(cyc, 1, 64'd0);
        @(posedge clk); #1;
        issue(4'b0000, 64'd3, 64'd5, 64'd15, 65);

        // Reset in the middle of a MUL
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = 4'b0000;
        src1      = 64'd11;
        src2      = 64'd13;
        repeat (10) @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        expect_at(cyc, 0, 64'd0);
        expect_at(cyc, 1, 64'd0);
        expect_at(cyc, 2, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Drain: any late or stray response is caught by the monitor
        repeat (100) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
